controle_moedas: RTL and testbench
==================================

# controle_moedas

Sequential front end of the vending machine, directly upstream of the price comparator. It edge-detects coin and button inputs and accumulates the inserted value into a 4-bit total. On a buy request it latches the product code and strobes the comparator's `enable` for one cycle. It then turns the comparator's verdict into a one-cycle deliver or refund pulse and clears the total; it also refunds on cancel or inactivity timeout.

## Interface
- `TIMEOUT_CICLOS`, default 1000: idle cycles in ACUMULANDO before an automatic refund; must be ≥ 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `moeda1`  in  1  coin sensor for value 1; a rising edge is one coin.
- `moeda2`  in  1  coin sensor for value 2; a rising edge is one coin.
- `selecao`  in  3  product code, sampled on the accepted `confirmar` edge.
- `confirmar`  in  1  buy button; acts on its rising edge.
- `cancelar`  in  1  cancel button; acts on its rising edge.
- `liberarProduto`  in  1  comparator verdict: price matched.
- `devolverMoedas`  in  1  comparator verdict: refund.
- `valorMoedas`  out  4  accumulated total, registered, drives the comparator.
- `valorProduto`  out  3  latched product code, registered, drives the comparator.
- `enable`  out  1  comparator strobe.
- `entregar`  out  1  one-cycle deliver pulse.
- `devolver`  out  1  one-cycle refund pulse.
- `valorDevolvido`  out  4  amount refunded; valid while `devolver` is high.
- `moeda_rejeitada`  out  1  one-cycle pulse when a coin edge is not accepted.
- `ocupado`  out  1  high in COMPARANDO, ENTREGA and DEVOLUCAO.

## Operation
- Every input goes through a rising-edge detector (registered previous value). Level inputs held high count once.
- States:
  - OCIOSO: total = 0. An accepted coin adds its value and moves to ACUMULANDO. `confirmar` and `cancelar` are ignored.
  - ACUMULANDO:
    - Accepted coins add value; the timeout counter clears on each accepted coin.
    - `cancelar` edge → DEVOLUCAO. `cancelar` has priority over `confirmar`.
    - `confirmar` edge → COMPARANDO and latches `selecao` into `valorProduto`.
    - Counter reaching `TIMEOUT_CICLOS-1` → DEVOLUCAO.
  - COMPARANDO, 1 cycle: `enable` = 1. Sample `liberarProduto` → ENTREGA, otherwise → DEVOLUCAO. The verdict is sampled only in this cycle.
  - ENTREGA, 1 cycle: `entregar` = 1, total cleared → OCIOSO.
  - DEVOLUCAO, 1 cycle: `devolver` = 1, `valorDevolvido` = total, total cleared → OCIOSO.
- Arithmetic:
  - Add in 5 bits.
  - If the sum exceeds 15, that cycle's coin edges are all rejected and the total is unchanged.
  - `moeda1` and `moeda2` edges in the same cycle add 3 as one operation.
- Coin edges in COMPARANDO, ENTREGA or DEVOLUCAO are rejected: `moeda_rejeitada` pulses and the total is unchanged.
- A coin edge coincident with `confirmar` or `cancelar` in ACUMULANDO is added first. The comparator or the refund sees the updated total.

## Timing
- Reset values: all outputs 0, state OCIOSO, timeout counter 0, edge-detector registers 0.
- Input edge at cycle N (input high at N, low at N-1) → `valorMoedas` updated at N+1.
- `confirmar` edge at N → `enable` high during N+1 → `entregar` or `devolver` high during N+2 → `valorMoedas` = 0 at N+3.
- `cancelar` edge at N → `devolver` high during N+1.
- Timeout: with no accepted coin after cycle N, `devolver` is high TIMEOUT_CICLOS+1 cycles after N.
- `enable` is never high except in COMPARANDO. The comparator holds stale outputs otherwise.
- `rst_n` low mid-transaction aborts immediately with no refund pulse. Inputs held high across reset deassertion do not produce edges.

## Structure
- Package `maquina_pkg`:
  - state enum (OCIOSO, ACUMULANDO, COMPARANDO, ENTREGA, DEVOLUCAO);
  - `VALOR_MOEDA1` = 1, `VALOR_MOEDA2` = 2, `VALOR_MAX` = 15;
  - product code constants 3'b001–3'b110, shared with the comparator.
- Sub-module `detector_borda` (clk, rst_n, in → pulse), instanced four times.
- The timeout counter width is `$clog2(TIMEOUT_CICLOS)`.

## Test plan
- Purchase: `moeda2` edge, then `selecao`=3'b001 with `confirmar` edge, comparator model matches → `enable` 1 cycle, `entregar` pulse, `valorMoedas` returns to 0.
- Mismatch: `moeda1` ×3 (total 3), `selecao`=3'b011 (price 5), confirm → `devolver` pulse with `valorDevolvido`=3.
- Saturation: `moeda2` ×7 (total 14), then `moeda2` → `moeda_rejeitada` pulse, total stays 14; then `moeda1` → total 15.
- Simultaneous events:
  - `moeda1` and `moeda2` edges in the same cycle → total +3;
  - `cancelar` and `confirmar` edges together → `devolver`, no `enable`.
- Timeout with `TIMEOUT_CICLOS`=8: `moeda1` then idle → `devolver` 9 cycles later with value 1. A coin at cycle 5 restarts the count.
- Reset and busy:
  - `rst_n` low during COMPARANDO → all outputs 0, no pulses.
  - Coin edge during ENTREGA → rejected, next transaction starts from 0.

Source files
------------

// File: rtl/maquina_pkg.sv
// maquina_pkg -- shared definitions for the vending machine front end and
// the price comparator.
//   estado_t     : controller states
//   VALOR_*      : coin values and the largest total the 4-bit bus can carry
//   PRODUTO_*    : product codes understood by the comparator
//   soma_moedas  : 5-bit sum of the current total and this cycle's coins
package maquina_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    ACUMULANDO = 3'd1,
    COMPARANDO = 3'd2,
    ENTREGA    = 3'd3,
    DEVOLUCAO  = 3'd4
  } estado_t;

  localparam logic [3:0] VALOR_MOEDA1 = 4'd1;
  localparam logic [3:0] VALOR_MOEDA2 = 4'd2;
  localparam logic [3:0] VALOR_MAX    = 4'd15;

  localparam logic [2:0] PRODUTO_1 = 3'b001;
  localparam logic [2:0] PRODUTO_2 = 3'b010;
  localparam logic [2:0] PRODUTO_3 = 3'b011;
  localparam logic [2:0] PRODUTO_4 = 3'b100;
  localparam logic [2:0] PRODUTO_5 = 3'b101;
  localparam logic [2:0] PRODUTO_6 = 3'b110;

  // Both coins in the same cycle are summed as a single operation so the
  // overflow decision covers them together.
  function automatic logic [4:0] soma_moedas(logic [3:0] total, logic m1, logic m2);
    logic [4:0] s;
    s = {1'b0, total};
    if (m1) s = s + {1'b0, VALOR_MOEDA1};
    if (m2) s = s + {1'b0, VALOR_MOEDA2};
    return s;
  endfunction

endpackage

// File: rtl/controle_moedas_if.sv
// controle_moedas_if -- link between the coin controller and the comparator.
//   valorMoedas    : accumulated total (controller -> comparator)
//   valorProduto   : latched product code (controller -> comparator)
//   enable         : one-cycle compare strobe (controller -> comparator)
//   liberarProduto : verdict, price matched (comparator -> controller)
//   devolverMoedas : verdict, refund (comparator -> controller)
interface controle_moedas_if;
  logic [3:0] valorMoedas;
  logic [2:0] valorProduto;
  logic       enable;
  logic       liberarProduto;
  logic       devolverMoedas;

  modport master (
    output valorMoedas, valorProduto, enable,
    input  liberarProduto, devolverMoedas
  );

  modport slave (
    input  valorMoedas, valorProduto, enable,
    output liberarProduto, devolverMoedas
  );
endinterface

// File: rtl/controle_moedas_detector_borda.sv
// detector_borda -- rising-edge detector.
//   clk, rst_n : clock and asynchronous active-low reset
//   in         : level input
//   pulse      : high for the cycle in which 'in' is high after being low
// The armed flag suppresses the first cycle after reset so that an input
// already held high when reset is released is not taken as an edge.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);
  logic anterior_q, anterior_d;
  logic armado_q, armado_d;

  always_comb begin
    anterior_d = in;
    armado_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anterior_q <= 1'b0;
      armado_q   <= 1'b0;
    end else begin
      anterior_q <= anterior_d;
      armado_q   <= armado_d;
    end
  end

  assign pulse = in & ~anterior_q & armado_q;
endmodule

// File: rtl/controle_moedas.sv
// controle_moedas -- coin accumulator and purchase sequencer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   moeda1, moeda2      : coin sensors (values 1 and 2), edge-triggered
//   selecao             : product code, captured on the confirm edge
//   confirmar, cancelar : buy / cancel buttons, edge-triggered
//   cmp                 : comparator link (total, product, enable, verdict)
//   entregar, devolver  : one-cycle deliver / refund pulses
//   valorDevolvido      : refunded amount, valid while devolver is high
//   moeda_rejeitada     : one-cycle pulse for every refused coin edge
//   ocupado             : transaction in progress (compare/deliver/refund)
module controle_moedas
  import maquina_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     moeda1,
  input  logic                     moeda2,
  input  logic [2:0]               selecao,
  input  logic                     confirmar,
  input  logic                     cancelar,
  controle_moedas_if.master        cmp,
  output logic                     entregar,
  output logic                     devolver,
  output logic [3:0]               valorDevolvido,
  output logic                     moeda_rejeitada,
  output logic                     ocupado
);
  localparam int CNT_W = $clog2(TIMEOUT_CICLOS);
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

  // Edge detectors: bit 0 moeda1, 1 moeda2, 2 confirmar, 3 cancelar.
  logic [3:0] entradas;
  logic [3:0] bordas;
  assign entradas = {cancelar, confirmar, moeda2, moeda1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_borda
      detector_borda u_detector (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (entradas[gi]),
        .pulse (bordas[gi])
      );
    end
  endgenerate

  estado_t          estado_q, estado_d;
  logic [3:0]       total_q, total_d;
  logic [2:0]       produto_q, produto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] soma;
  logic       ha_moeda;
  logic       aceita;

  always_comb begin
    estado_d  = estado_q;
    total_d   = total_q;
    produto_d = produto_q;
    cnt_d     = '0;

    soma     = soma_moedas(total_q, bordas[0], bordas[1]);
    ha_moeda = bordas[0] | bordas[1];
    aceita   = ha_moeda && (estado_q == OCIOSO || estado_q == ACUMULANDO) &&
               (soma <= {1'b0, VALOR_MAX});

    unique case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          total_d  = soma[3:0];
          estado_d = ACUMULANDO;
        end
      end
      ACUMULANDO: begin
        // Coins are added before any exit so the comparator or the refund
        // sees the updated total. An accepted coin restarts the idle count
        // and therefore also suppresses a timeout in the same cycle.
        if (aceita) total_d = soma[3:0];
        else        cnt_d   = cnt_q + 1'b1;
        if (bordas[3]) begin
          estado_d = DEVOLUCAO;
        end else if (bordas[2]) begin
          estado_d  = COMPARANDO;
          produto_d = selecao;
        end else if (!aceita && cnt_q == LIMITE) begin
          estado_d = DEVOLUCAO;
        end
      end
      COMPARANDO: begin
        // A contradictory verdict (both asserted) falls back to a refund.
        estado_d = (cmp.liberarProduto && !cmp.devolverMoedas) ? ENTREGA : DEVOLUCAO;
      end
      ENTREGA: begin
        total_d  = '0;
        estado_d = OCIOSO;
      end
      DEVOLUCAO: begin
        total_d  = '0;
        estado_d = OCIOSO;
      end
      default: begin
        total_d  = '0;
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      total_q   <= '0;
      produto_q <= '0;
      cnt_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      total_q   <= total_d;
      produto_q <= produto_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cmp.valorMoedas  = total_q;
  assign cmp.valorProduto = produto_q;
  assign cmp.enable       = (estado_q == COMPARANDO);
  assign entregar         = (estado_q == ENTREGA);
  assign devolver         = (estado_q == DEVOLUCAO);
  assign valorDevolvido   = devolver ? total_q : 4'd0;
  assign moeda_rejeitada  = ha_moeda & ~aceita;
  assign ocupado          = (estado_q == COMPARANDO) || (estado_q == ENTREGA) ||
                            (estado_q == DEVOLUCAO);
endmodule

// File: tb/tb_controle_moedas.sv
// tb_controle_moedas -- scoreboard bench for controle_moedas.
// Stimulus pushes the pulses it expects (kind, cycle, value) into a queue;
// a negedge monitor pops one entry per observed pulse and compares it.
module tb_controle_moedas;
  import maquina_pkg::*;

  localparam int EV_ENABLE  = 1;
  localparam int EV_ENTREGA = 2;
  localparam int EV_DEVOLVE = 3;
  localparam int EV_REJEITA = 4;

  typedef struct {
    int kind;
    int cyc;
    int valor;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       moeda1, moeda2, confirmar, cancelar;
  logic [2:0] selecao;
  logic       entregar, devolver, moeda_rejeitada, ocupado;
  logic [3:0] valorDevolvido;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  evt_t fila[$];

  controle_moedas_if cmp_if ();

  controle_moedas #(.TIMEOUT_CICLOS(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .moeda1          (moeda1),
    .moeda2          (moeda2),
    .selecao         (selecao),
    .confirmar       (confirmar),
    .cancelar        (cancelar),
    .cmp             (cmp_if.master),
    .entregar        (entregar),
    .devolver        (devolver),
    .valorDevolvido  (valorDevolvido),
    .moeda_rejeitada (moeda_rejeitada),
    .ocupado         (ocupado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model with its own price table.
  function automatic logic [3:0] preco(logic [2:0] p);
    case (p)
      PRODUTO_1: return 4'd2;
      PRODUTO_2: return 4'd3;
      PRODUTO_3: return 4'd5;
      PRODUTO_4: return 4'd6;
      PRODUTO_5: return 4'd8;
      PRODUTO_6: return 4'd10;
      default:   return 4'd15;
    endcase
  endfunction

  assign cmp_if.liberarProduto = (cmp_if.valorMoedas == preco(cmp_if.valorProduto));
  assign cmp_if.devolverMoedas = !cmp_if.liberarProduto;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_evt(input int k, input int c, input int v);
    evt_t e;
    e.kind  = k;
    e.cyc   = c;
    e.valor = v;
    fila.push_back(e);
  endtask

  task automatic take(input int k, input int v);
    evt_t e;
    $display("evt cycle=%0d kind=%0d value=%0d", cyc, k, v);
    if (fila.size() == 0) begin
      check_val("unexpected_pulse", k, 0);
    end else begin
      e = fila.pop_front();
      check_val("evt_kind", k, e.kind);
      check_val("evt_cycle", cyc, e.cyc);
      check_val("evt_value", v, e.valor);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmp_if.enable)   take(EV_ENABLE, 0);
      if (entregar)        take(EV_ENTREGA, 0);
      if (devolver)        take(EV_DEVOLVE, int'(valorDevolvido));
      if (moeda_rejeitada) take(EV_REJEITA, 0);
      if (cmp_if.enable || entregar || devolver) check_val("ocupado", int'(ocupado), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs high for the current cycle, low for the next; returns two cycles later.
  task automatic drive(input logic m1, input logic m2, input logic cf,
                       input logic cn, input logic [2:0] sel);
    moeda1 = m1; moeda2 = m2; confirmar = cf; cancelar = cn; selecao = sel;
    step();
    moeda1 = 1'b0; moeda2 = 1'b0; confirmar = 1'b0; cancelar = 1'b0;
    step();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (fila.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    check_val(tag, fila.size(), 0);
    fila.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    moeda1 = 1'b0; moeda2 = 1'b0; confirmar = 1'b0; cancelar = 1'b0;
    selecao = 3'b000;
    step();
    step();
    check_val("rst_valorMoedas", int'(cmp_if.valorMoedas), 0);
    check_val("rst_valorProduto", int'(cmp_if.valorProduto), 0);
    check_val("rst_enable", int'(cmp_if.enable), 0);
    check_val("rst_entregar", int'(entregar), 0);
    check_val("rst_devolver", int'(devolver), 0);
    check_val("rst_ocupado", int'(ocupado), 0);
    rst_n = 1'b1;
    step();
    step();

    // Purchase: 2 inserted, product 001 costs 2.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    check_val("compra_total", int'(cmp_if.valorMoedas), 2);
    push_evt(EV_ENABLE, cyc + 1, 0);
    push_evt(EV_ENTREGA, cyc + 2, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, PRODUTO_1);
    check_val("compra_produto", int'(cmp_if.valorProduto), int'(PRODUTO_1));
    step();
    check_val("compra_total_zero", int'(cmp_if.valorMoedas), 0);
    drain("compra_drain");

    // Mismatch: 3 inserted, product 011 costs 5.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    check_val("divergente_total", int'(cmp_if.valorMoedas), 3);
    push_evt(EV_ENABLE, cyc + 1, 0);
    push_evt(EV_DEVOLVE, cyc + 2, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, PRODUTO_3);
    drain("divergente_drain");

    // Saturation at 15.
    repeat (7) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    check_val("sat_total14", int'(cmp_if.valorMoedas), 14);
    push_evt(EV_REJEITA, cyc, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    check_val("sat_rejeitada_total", int'(cmp_if.valorMoedas), 14);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    check_val("sat_total15", int'(cmp_if.valorMoedas), 15);
    push_evt(EV_DEVOLVE, cyc + 1, 15);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    drain("sat_drain");

    // Both coins together, then cancel and confirm together.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    check_val("simult_total3", int'(cmp_if.valorMoedas), 3);
    push_evt(EV_DEVOLVE, cyc + 1, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, PRODUTO_2);
    drain("simult_drain");

    // Timeout after 8 idle cycles.
    push_evt(EV_DEVOLVE, cyc + 9, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    check_val("timeout_total", int'(cmp_if.valorMoedas), 1);
    drain("timeout_drain");

    // A coin 5 cycles later restarts the count.
    begin
      int c0;
      c0 = cyc;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      repeat (3) step();
      check_val("restart_at5", cyc - c0, 5);
      push_evt(EV_DEVOLVE, cyc + 9, 2);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      check_val("restart_total", int'(cmp_if.valorMoedas), 2);
      drain("restart_drain");
    end

    // Coin edge during ENTREGA is rejected; next transaction starts from 0.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    push_evt(EV_ENABLE, cyc + 1, 0);
    push_evt(EV_ENTREGA, cyc + 2, 0);
    push_evt(EV_REJEITA, cyc + 2, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, PRODUTO_1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    check_val("ocupado_total_zero", int'(cmp_if.valorMoedas), 0);
    drain("ocupado_drain");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    check_val("ocupado_novo_total", int'(cmp_if.valorMoedas), 1);
    push_evt(EV_DEVOLVE, cyc + 1, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    drain("ocupado_novo_drain");

    // Reset while in COMPARANDO, with moeda1 held across release.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    confirmar = 1'b1;
    selecao = PRODUTO_1;
    step();
    rst_n = 1'b0;
    moeda1 = 1'b1;
    #1;
    check_val("rstmid_enable", int'(cmp_if.enable), 0);
    check_val("rstmid_total", int'(cmp_if.valorMoedas), 0);
    check_val("rstmid_produto", int'(cmp_if.valorProduto), 0);
    check_val("rstmid_ocupado", int'(ocupado), 0);
    check_val("rstmid_devolver", int'(devolver), 0);
    confirmar = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check_val("rstmid_held_coin", int'(cmp_if.valorMoedas), 0);
    moeda1 = 1'b0;
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    check_val("rstmid_after_total", int'(cmp_if.valorMoedas), 1);
    push_evt(EV_DEVOLVE, cyc + 1, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    drain("rstmid_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
